vending_machine_gen: RTL

//   Parametrised vending-machine controller, successor of the fixed 4-item machine.

---
 rtl/vending_machine_gen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vending_machine_gen.sv
// rtl/vending_machine_gen.sv - parametrised vending-machine controller with price table and stock
//
// Purpose: takes coin and keypad pulses from the front end and drives the
// dispenser and coin-return actuators. It supports a configurable item count,
// a price per item, stock per item with sold-out and restock, cancel with
// refund, and rejection of coins that arrive outside a purchase.
// The currency unit is $10: coin_10 is worth 1 unit and coin_50 is worth 5 units.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   item          item index for sel / restock
//   sel           start a purchase of item (1-cycle pulse)
//   coin_10       1 unit inserted (1-cycle pulse)
//   coin_50       5 units inserted (1-cycle pulse)
//   cancel        abort the purchase and refund the credit
//   restock       load stock[item] with STOCK_MAX (accepted only in IDLE)
//   price_due     units still owed while paying, otherwise 0
//   item_rels     {1'b1,item} for one cycle on release, otherwise 0
//   change_return one cycle high per unit returned
//   sold_out      pulse: sel rejected because stock[item] is 0
//   coin_reject   pulse: coin arrived outside a purchase and was not credited
module vending_machine_gen #(
    parameter int ITEM_W  = 2,
    parameter int PRICE_W = 6,
    parameter logic [(2**ITEM_W)*PRICE_W-1:0] PRICE_TABLE = {6'd5, 6'd4, 6'd3, 6'd2},
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 3,
    parameter int STOCK_MAX  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ITEM_W-1:0]  item,
    input  logic               sel,
    input  logic               coin_10,
    input  logic               coin_50,
    input  logic               cancel,
    input  logic               restock,
    output logic [PRICE_W-1:0] price_due,
    output logic [ITEM_W:0]    item_rels,
    output logic               change_return,
    output logic               sold_out,
    output logic               coin_reject
);

    localparam int N_ITEMS = 2**ITEM_W;

    typedef enum logic [1:0] {IDLE, PAY, VEND, CHANGE} state_t;

    state_t               state, state_nx;
    logic [ITEM_W-1:0]    cur_item, cur_item_nx;
    logic [PRICE_W-1:0]   price, price_nx;
    logic [PRICE_W-1:0]   credit, credit_nx;
    logic [PRICE_W-1:0]   refund, refund_nx;
    logic [PRICE_W-1:0]   price_due_nx;
    logic [ITEM_W:0]      item_rels_nx;
    logic                 change_nx, sold_nx, reject_nx;
    logic                 stock_load, stock_dec;
    logic [STOCK_W-1:0]   stock [N_ITEMS];
    logic [PRICE_W-1:0]   coin_units, credit_sum, sel_price;

    // A simultaneous 10 and 50 credits 6 units.
    assign coin_units = PRICE_W'(coin_10) + (coin_50 ? PRICE_W'(5) : '0);
    assign credit_sum = credit + coin_units;
    assign sel_price  = PRICE_TABLE[item*PRICE_W +: PRICE_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cur_item      <= '0;
            price         <= '0;
            credit        <= '0;
            refund        <= '0;
            price_due     <= '0;
            item_rels     <= '0;
            change_return <= 1'b0;
            sold_out      <= 1'b0;
            coin_reject   <= 1'b0;
        end else begin
            state         <= state_nx;
            cur_item      <= cur_item_nx;
            price         <= price_nx;
            credit        <= credit_nx;
            refund        <= refund_nx;
            price_due     <= price_due_nx;
            item_rels     <= item_rels_nx;
            change_return <= change_nx;
            sold_out      <= sold_nx;
            coin_reject   <= reject_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (stock_load) begin
            stock[item] <= STOCK_W'(STOCK_MAX);
        end else if (stock_dec) begin
            stock[cur_item] <= stock[cur_item] - 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        cur_item_nx  = cur_item;
        price_nx     = price;
        credit_nx    = credit;
        refund_nx    = refund;
        price_due_nx = '0;
        item_rels_nx = '0;
        change_nx    = 1'b0;
        sold_nx      = 1'b0;
        reject_nx    = 1'b0;
        stock_load   = 1'b0;
        stock_dec    = 1'b0;
        case (state)
            IDLE: begin
                reject_nx = coin_10 | coin_50;
                if (sel) begin
                    if (stock[item] == '0) begin
                        sold_nx = 1'b1;
                    end else begin
                        cur_item_nx  = item;
                        price_nx     = sel_price;
                        credit_nx    = '0;
                        price_due_nx = sel_price;
                        state_nx     = PAY;
                    end
                end else if (restock) begin
                    stock_load = 1'b1;
                end
            end
            PAY: begin
                // Cancel wins even when the same-cycle coin would complete payment.
                if (cancel) begin
                    refund_nx = credit_sum;
                    credit_nx = '0;
                    if (credit_sum != '0) begin
                        state_nx  = CHANGE;
                        change_nx = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (credit_sum >= price) begin
                    state_nx     = VEND;
                    item_rels_nx = {1'b1, cur_item};
                    refund_nx    = credit_sum - price;
                    credit_nx    = '0;
                end else begin
                    credit_nx    = credit_sum;
                    price_due_nx = price - credit_sum;
                end
            end
            VEND: begin
                reject_nx = coin_10 | coin_50;
                stock_dec = 1'b1;
                if (refund != '0) begin
                    state_nx  = CHANGE;
                    change_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            CHANGE: begin
                // refund still counts the pulse shown this cycle; leave when it is the last one.
                reject_nx = coin_10 | coin_50;
                if (refund <= PRICE_W'(1)) begin
                    refund_nx = '0;
                    state_nx  = IDLE;
                end else begin
                    refund_nx = refund - 1'b1;
                    change_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
